// File: rtl/dmem_pkg.sv
// Shared types for the data memory controller.
//   state_t    : controller FSM states (CLEAR sweeps the array, IDLE serves requests)
//   dmem_rsp_t : response bundle {valid, err, rdata}; rdata width follows RSP_DATA_W,
//                which matches the controller's default DATA_W.
package dmem_pkg;
  localparam int RSP_DATA_W = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [RSP_DATA_W-1:0] rdata;
  } dmem_rsp_t;
endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with one synchronous byte-enable write port and one
// synchronous read port.
//   clk          : rising-edge clock
//   we/waddr     : write strobe and word address
//   wbe/wdata    : byte enables (bit k -> bits [8k+7:8k]) and write data
//   re/raddr     : read strobe and word address
//   rdata        : registered read data, updated only on edges with re=1
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int BE_W   = DATA_W / 8,
  parameter int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [BE_W-1:0]   wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wbe[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller for the load/store path: valid/ready request port,
// 1-cycle registered response, out-of-range reporting and a one-word-per-cycle
// clear engine that runs after reset and on request.
//   clk, reset            : clock, synchronous active-high reset
//   clear                 : start a full zero-clear (taken only in IDLE)
//   req_valid/req_ready   : request handshake; req_ready = IDLE && !clear
//   req_we/addr/wdata/be  : request fields
//   rsp_valid/rdata/err   : one-cycle response pulse; rdata/err held between responses
//   busy                  : clear in progress
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr;
  logic              accept, in_range, last;
  logic              wr_en, rd_en;
  logic [IW-1:0]     wr_addr;
  logic [BE_W-1:0]   wr_be;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] arr_rdata;
  logic              vld_q, err_q, rd_q;
  dmem_rsp_t         rsp;

  // Extra leading zero so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
  assign accept   = req_valid && req_ready;
  assign last     = (ptr == IW'(DEPTH - 1));

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = req_addr[IW-1:0];
    wr_be     = req_be;
    wr_data   = req_wdata;
    rd_en     = 1'b0;
    case (state)
      CLEAR: begin
        busy    = 1'b1;
        wr_en   = !reset;
        wr_addr = ptr;
        wr_be   = '1;
        wr_data = '0;
        if (last) state_nxt = IDLE;
      end
      IDLE: begin
        req_ready = !clear;
        if (clear) state_nxt = CLEAR;
        // Out-of-range requests never touch the array; reset blocks commits.
        wr_en = accept && req_we && in_range && !reset;
        rd_en = accept && !req_we && in_range;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      // Pointer parks at 0 outside CLEAR so the next sweep starts there.
      if (state == CLEAR && !last) ptr <= ptr + 1'b1;
      else                         ptr <= '0;
    end
  end

  // rd_q remembers whether the held response came from the array, so writes
  // and errors present zero data without a second data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        err_q <= !in_range;
        rd_q  <= !req_we && in_range;
      end
    end
  end

  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BE_W(BE_W), .IW(IW)) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wbe   (wr_be),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (req_addr[IW-1:0]),
    .rdata (arr_rdata)
  );

  always_comb begin
    rsp.valid = vld_q;
    rsp.err   = err_q;
    rsp.rdata = rd_q ? arr_rdata : '0;
  end

  assign rsp_valid = rsp.valid;
  assign rsp_err   = rsp.err;
  assign rsp_rdata = rsp.rdata;
endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;
  logic        clk = 1'b0;
  logic        reset, clear, req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;

  int errors = 0;
  int checks = 0;

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one edge; everything is sampled and driven 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request through its accepting edge and capture the response.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                        input logic [1:0] be, output logic v, output logic e,
                        output logic [15:0] d);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    step();
    v = rsp_valid; e = rsp_err; d = rsp_rdata;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  // Steps until req_ready rises (bounded); returns edges taken and whether
  // busy ever dropped early.
  task automatic wait_ready(output int n, output logic busy_bad);
    n = 0; busy_bad = 1'b0;
    while (req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
      if (req_ready !== 1'b1 && busy !== 1'b1) busy_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    int n; logic bb, v, e; logic [15:0] d;
    reset = 1'b1; clear = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    step(); step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h expected 0 0 0000", rsp_valid, rsp_err, rsp_rdata); end
    reset = 1'b0;
    wait_ready(n, bb);
    checks++; if (n != 64) begin errors++; $display("FAIL reset_clear_len: got %0d expected 64", n); end
    checks++; if (bb !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy: early=%b busy=%b expected 0 0", bb, busy); end
    do_req(1'b0, 8'd5, 16'h0, 2'b00, v, e, d);
    checks++; if (v !== 1'b1 || e !== 1'b0 || d !== 16'h0000) begin
      errors++; $display("FAIL reset_read5: got v=%b e=%b d=%h expected 1 0 0000", v, e, d); end
  endtask

  task automatic test_byte_enables();
    logic v, e; logic [15:0] d;
    do_req(1'b1, 8'd3, 16'hABCD, 2'b11, v, e, d);
    checks++; if (v !== 1'b1 || e !== 1'b0 || d !== 16'h0) begin
      errors++; $display("FAIL be_write_rsp: got v=%b e=%b d=%h expected 1 0 0000", v, e, d); end
    do_req(1'b1, 8'd3, 16'h1234, 2'b01, v, e, d);
    do_req(1'b1, 8'd3, 16'h5555, 2'b00, v, e, d);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL be_zero_rsp: got v=%b expected 1", v); end
    do_req(1'b0, 8'd3, 16'h0, 2'b00, v, e, d);
    checks++; if (d !== 16'hAB34 || e !== 1'b0) begin
      errors++; $display("FAIL be_merge: got d=%h e=%b expected ab34 0", d, e); end
    do_req(1'b1, 8'd63, 16'hC3A5, 2'b10, v, e, d);
    do_req(1'b0, 8'd63, 16'h0, 2'b00, v, e, d);
    checks++; if (d !== 16'hC300 || e !== 1'b0) begin
      errors++; $display("FAIL be_high_last: got d=%h e=%b expected c300 0", d, e); end
  endtask

  task automatic test_back_to_back();
    logic v1, v2, v3; logic [15:0] d1, d2, d3;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd7; req_wdata = 16'hBEEF; req_be = 2'b11;
    step();
    v1 = rsp_valid; d1 = rsp_rdata;
    req_we = 1'b0;
    step();
    v2 = rsp_valid; d2 = rsp_rdata;
    req_valid = 1'b0;
    step();
    v3 = rsp_valid; d3 = rsp_rdata;
    checks++; if (v1 !== 1'b1 || v2 !== 1'b1) begin
      errors++; $display("FAIL b2b_valid: got %b%b expected 11", v1, v2); end
    checks++; if (d1 !== 16'h0 || d2 !== 16'hBEEF) begin
      errors++; $display("FAIL b2b_data: got %h %h expected 0000 beef", d1, d2); end
    checks++; if (v3 !== 1'b0 || d3 !== 16'hBEEF) begin
      errors++; $display("FAIL b2b_pulse_hold: got v=%b d=%h expected 0 beef", v3, d3); end
  endtask

  task automatic test_out_of_range();
    logic v, e; logic [15:0] d;
    do_req(1'b1, 8'd64, 16'hFFFF, 2'b11, v, e, d);
    checks++; if (v !== 1'b1 || e !== 1'b1 || d !== 16'h0) begin
      errors++; $display("FAIL oor_write: got v=%b e=%b d=%h expected 1 1 0000", v, e, d); end
    do_req(1'b0, 8'd64, 16'h0, 2'b00, v, e, d);
    checks++; if (v !== 1'b1 || e !== 1'b1 || d !== 16'h0) begin
      errors++; $display("FAIL oor_read: got v=%b e=%b d=%h expected 1 1 0000", v, e, d); end
    do_req(1'b0, 8'd255, 16'h0, 2'b00, v, e, d);
    checks++; if (e !== 1'b1 || d !== 16'h0) begin
      errors++; $display("FAIL oor_top: got e=%b d=%h expected 1 0000", e, d); end
    do_req(1'b0, 8'd0, 16'h0, 2'b00, v, e, d);
    checks++; if (e !== 1'b0 || d !== 16'h0) begin
      errors++; $display("FAIL oor_addr0: got e=%b d=%h expected 0 0000", e, d); end
  endtask

  task automatic test_clear_vs_req();
    int n; logic bb, v, e; logic [15:0] d;
    clear = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd7;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b expected 0", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL clr_enter: got v=%b busy=%b expected 0 1", rsp_valid, busy); end
    clear = 1'b0; req_valid = 1'b0;
    wait_ready(n, bb);
    // One edge to enter CLEAR already taken, so DEPTH+1 total.
    checks++; if (n + 1 != 65 || bb !== 1'b0) begin
      errors++; $display("FAIL clr_len: got %0d early=%b expected 65 0", n + 1, bb); end
    do_req(1'b0, 8'd7, 16'h0, 2'b00, v, e, d);
    checks++; if (d !== 16'h0 || e !== 1'b0) begin
      errors++; $display("FAIL clr_addr7: got d=%h e=%b expected 0000 0", d, e); end
  endtask

  task automatic test_reset_mid();
    int n; logic bb, v, e; logic [15:0] d;
    do_req(1'b1, 8'd9, 16'h1357, 2'b11, v, e, d);
    do_req(1'b0, 8'd9, 16'h0, 2'b00, v, e, d);
    checks++; if (v !== 1'b1 || d !== 16'h1357) begin
      errors++; $display("FAIL mid_read: got v=%b d=%h expected 1 1357", v, d); end
    reset = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got v=%b d=%h rdy=%b busy=%b expected 0 0000 0 1",
                         rsp_valid, rsp_rdata, req_ready, busy); end
    reset = 1'b0;
    wait_ready(n, bb);
    checks++; if (n != 64 || bb !== 1'b0) begin
      errors++; $display("FAIL mid_clear_len: got %0d early=%b expected 64 0", n, bb); end
    do_req(1'b0, 8'd9, 16'h0, 2'b00, v, e, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL mid_addr9: got %h expected 0000", d); end
  endtask

  initial begin
    test_reset();
    test_byte_enables();
    test_back_to_back();
    test_out_of_range();
    test_clear_vs_req();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised data memory for the 16-bit processor's load/store path. It generalises the existing 64×16 data memory with configurable width and depth, byte-enable writes, a registered read with valid/ready handshake, out-of-range error reporting, and a sequential clear engine. Clearing zeroes one word per cycle and replaces the single-cycle bulk clear. The block sits between the load/store stage and the storage array; the load/store stage drives requests and consumes responses.

## Interface
Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8
- ADDR_W, 8, request address width
- DEPTH, 64, number of words; DEPTH ≤ 2**ADDR_W
- BE_W, DATA_W/8, byte-enable width (derived, not overridden)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  request a full zero-clear while idle
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  BE_W  byte enables; bit k covers bits [8k+7:8k]
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  address ≥ DEPTH
- busy  out  1  clear in progress

## Operation
- The FSM has two states: CLEAR and IDLE.
- **Reset:**
  - The reset edge forces state CLEAR and clear pointer 0.
  - Outputs after reset: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- **CLEAR state:**
  - Each edge with reset low writes 0 to mem[ptr] and increments ptr.
  - The edge that clears ptr==DEPTH-1 moves the FSM to IDLE.
  - req_ready=0 and busy=1 throughout.
- **IDLE state:**
  - req_ready = !clear (combinational); busy=0.
  - clear=1 in IDLE: moves to CLEAR with ptr=0 on the next edge. Any simultaneous request is not accepted, because ready is low.
- **Accepted read:** mem[addr] is returned on the next cycle.
- **Accepted write:** for each byte k with req_be[k]=1, mem[addr] byte k takes req_wdata byte k; other bytes are unchanged. be=0 is a legal no-op write and still produces a response.
- **Out-of-range** (req_addr ≥ DEPTH): memory is untouched; the response carries rsp_err=1 and rsp_rdata=0.
- **One response per request:** every accepted request produces exactly one response. The response path has no backpressure; the consumer must take it.
- **Reset mid-operation:** a pending response is dropped (rsp_valid=0 after the reset edge) and the clear restarts from ptr 0.
- **Memory contents:** undefined between power-up and completion of the first clear; never read before it.

## Timing
- **Read latency:** 1 cycle. A request accepted at edge N gives rsp_valid=1 with data during cycle N..N+1, registered at edge N.
- **Write commit:** at the accepting edge.
- **Read-after-write:** a read of the same address accepted at edge N+1 returns the new data.
- **Throughput:** one request per cycle, back-to-back.
- **Clear duration:**
  - req_ready first rises after exactly DEPTH edges with reset low following reset release.
  - A clear requested from IDLE takes DEPTH+1 edges to complete.
- **Response pulse:** rsp_valid is high for exactly one cycle per request. rsp_rdata and rsp_err are held until the next response.
- **Pointer:** counts 0..DEPTH-1 and never wraps.

## Structure
- **Package dmem_pkg:**
  - state enum {CLEAR, IDLE}
  - response struct {valid, err, rdata} (parametrised via localparam defaults)
- **Sub-module dmem_array:**
  - DEPTH×DATA_W storage
  - synchronous byte-enable write port
  - synchronous read port
  - a single combined write path for both clear writes and request writes, muxed by the FSM
- **Top level:** FSM, pointer counter, handshake, range check, response register.

## Test plan
- **Reset clear:** reset 1 cycle, release -> busy=1 and req_ready=0 for 64 edges, then req_ready=1 and busy=0; a read of addr 5 returns 0x0000.
- **Byte enables:**
  - Write addr 3 data 0xABCD be=11, then write addr 3 data 0x1234 be=01 -> a read of addr 3 returns 0xAB34 with rsp_err=0.
- **Back-to-back:** write addr 7 0xBEEF then read addr 7 on consecutive cycles -> second response 0xBEEF one cycle after the read is accepted; rsp_valid high in two consecutive cycles.
- **Out-of-range:** write addr 64 data 0xFFFF, then read addr 64 -> both responses have rsp_err=1 and rsp_rdata=0. Memory is unchanged: addr 0 still reads 0.
- **Clear versus request:**
  - clear=1 with req_valid=1 in IDLE -> request not accepted; CLEAR entered.
  - After 65 edges, a previously written addr 7 reads 0.
- **Reset mid-operation:** assert reset on the cycle after a read is accepted -> no rsp_valid; clear restarts, and req_ready stays low for 64 edges after release.
